dual_mode_timer_core: RTL and testbench

Seconds-domain core of the two-mode timer: a 25-bit prescaler divides the system clock to a one-second tick, which drives a BCD minutes:seconds counter that either counts up (stopwatch) or down (countdown). It sits directly downstream of the 25-bit prescaler register stage, holding its next-count logic and consuming its wrap. Its registered BCD digits feed the display/driver stage.

---
 rtl/dual_mode_timer_core.sv | 162 ++++++++++++++++
 tb/tb_dual_mode_timer_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_mode_timer_core.sv
// Seconds-domain timer core: prescaler to a one-second tick driving a BCD
// mm:ss counter that counts up (stopwatch) or down (countdown).
module dual_mode_timer_core #(
  parameter int unsigned DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       tick,
  output logic       done
);

  localparam logic [24:0] PRESC_LAST = 25'(DIV - 1);
  localparam logic [15:0] TIME_MAX   = 16'h9959;
  localparam logic [15:0] TIME_ZERO  = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] presc_q, presc_d;
  logic [15:0] time_q, time_d;
  logic        mode_q, mode_d;
  logic        tick_q, tick_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic [15:0] step_val;
  logic        wrap;

  function automatic logic preset_ok(input logic [7:0] m, input logic [7:0] s);
    return (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9) && (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
  endfunction

  // Callers never pass 99:59, so the minutes tens digit cannot overflow.
  function automatic logic [15:0] bcd_up(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Callers never pass 00:00, so the minutes tens digit cannot underflow.
  function automatic logic [15:0] bcd_down(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign wrap = (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    time_d   = time_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    step_val = mode_q ? bcd_down(time_q) : bcd_up(time_q);
    if (clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      time_d  = TIME_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            if (mode && preset_ok(preset_min, preset_sec)) time_d = {preset_min, preset_sec};
          end else if (start_stop) begin
            mode_d  = mode;
            presc_d = '0;
            // Starting at the terminal value has nothing to count; a stopwatch
            // parked at 99:59 is treated like a countdown parked at 00:00.
            if (mode ? (time_q == TIME_ZERO) : (time_q == TIME_MAX)) state_d = S_DONE;
            else state_d = S_RUN;
          end
        end
        S_RUN: begin
          presc_d = wrap ? '0 : presc_q + 25'd1;
          if (wrap) begin
            tick_d = 1'b1;
            time_d = step_val;
            if (mode_q ? (step_val == TIME_ZERO) : (step_val == TIME_MAX)) state_d = S_DONE;
            else if (start_stop) state_d = S_PAUSE;
          end else if (start_stop) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start_stop) state_d = S_RUN;
        end
        default: begin
          state_d = S_DONE;
        end
      endcase
    end
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      time_q    <= TIME_ZERO;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign min_bcd = time_q[15:8];
  assign sec_bcd = time_q[7:0];
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dual_mode_timer_core.sv
// Scoreboard bench: two cores (DIV=4 and DIV=8) share clk/rst; expected output
// snapshots are queued per cycle and a negedge monitor compares them.
module tb_dual_mode_timer_core;

  logic clk, rst;
  logic a_mode, a_ss, a_clear, a_load;
  logic [7:0] a_pm, a_ps, a_min, a_sec;
  logic a_run, a_tick, a_done;
  logic b_mode, b_ss, b_clear, b_load;
  logic [7:0] b_pm, b_ps, b_min, b_sec;
  logic b_run, b_tick, b_done;

  dual_mode_timer_core #(.DIV(4)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .start_stop(a_ss), .clear(a_clear),
    .load(a_load), .preset_min(a_pm), .preset_sec(a_ps), .min_bcd(a_min),
    .sec_bcd(a_sec), .running(a_run), .tick(a_tick), .done(a_done)
  );

  dual_mode_timer_core #(.DIV(8)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .start_stop(b_ss), .clear(b_clear),
    .load(b_load), .preset_min(b_pm), .preset_sec(b_ps), .min_bcd(b_min),
    .sec_bcd(b_sec), .running(b_run), .tick(b_tick), .done(b_done)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [7:0]  mn;
    logic [7:0]  sc;
    logic        run;
    logic        tk;
    logic        dn;
    logic [95:0] nm;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   fin = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // Monitor: compare every snapshot due this cycle; any tick not announced is an error.
  always @(negedge clk) begin
    bit matched_a, matched_b;
    logic [18:0] got, want;
    matched_a = 1'b0;
    matched_b = 1'b0;
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        got  = (q[i].dut == 0) ? {a_min, a_sec, a_run, a_tick, a_done}
                               : {b_min, b_sec, b_run, b_tick, b_done};
        want = {q[i].mn, q[i].sc, q[i].run, q[i].tk, q[i].dn};
        if (q[i].tk && q[i].dut == 0) matched_a = 1'b1;
        if (q[i].tk && q[i].dut == 1) matched_b = 1'b1;
        checks++;
        if (got !== want) begin
          errs++;
          $display("FAIL %s dut%0d cyc%0d: got %h:%h run=%b tick=%b done=%b, required %h:%h run=%b tick=%b done=%b",
                   q[i].nm, q[i].dut, cyc, got[18:11], got[10:3], got[2], got[1], got[0],
                   want[18:11], want[10:3], want[2], want[1], want[0]);
        end
      end
    end
    if (a_tick && !matched_a) begin
      checks++; errs++;
      $display("FAIL stray_tick dut0 cyc%0d: got tick=1, required tick=0", cyc);
    end
    if (b_tick && !matched_b) begin
      checks++; errs++;
      $display("FAIL stray_tick dut1 cyc%0d: got tick=1, required tick=0", cyc);
    end
    if (fin) begin
      foreach (q[i]) begin
        if (q[i].cyc > cyc) begin
          checks++; errs++;
          $display("FAIL %s dut%0d: snapshot for cyc%0d never reached, required it by cyc%0d",
                   q[i].nm, q[i].dut, q[i].cyc, cyc);
        end
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
  end

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic push(input int d, input int c, input logic [7:0] m, input logic [7:0] s,
                      input logic r, input logic t, input logic dn, input logic [95:0] nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.mn = m; e.sc = s; e.run = r; e.tk = t; e.dn = dn; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic act_a(input logic c, input logic l, input logic s, input logic [7:0] em,
                       input logic [7:0] es, input logic er, input logic et, input logic ed,
                       input logic [95:0] nm);
    a_clear = c; a_load = l; a_ss = s;
    push(0, cyc + 1, em, es, er, et, ed, nm);
    step();
    a_clear = 1'b0; a_load = 1'b0; a_ss = 1'b0;
  endtask

  task automatic act_b(input logic c, input logic l, input logic s, input logic [7:0] em,
                       input logic [7:0] es, input logic er, input logic et, input logic ed,
                       input logic [95:0] nm);
    b_clear = c; b_load = l; b_ss = s;
    push(1, cyc + 1, em, es, er, et, ed, nm);
    step();
    b_clear = 1'b0; b_load = 1'b0; b_ss = 1'b0;
  endtask

  initial begin
    int k, d, r, t;
    rst = 1'b1;
    {a_mode, a_ss, a_clear, a_load, a_pm, a_ps} = '0;
    {b_mode, b_ss, b_clear, b_load, b_pm, b_ps} = '0;
    step(); step();
    rst = 1'b0;
    push(0, cyc, 8'h00, 8'h00, 0, 0, 0, "reset");
    push(1, cyc, 8'h00, 8'h00, 0, 0, 0, "reset");
    step();

    // Stopwatch start, then asynchronous reset mid-RUN.
    a_mode = 1'b0;
    k = cyc;
    push(0, k + 5, 8'h00, 8'h01, 1, 1, 0, "sw_tick1");
    push(0, k + 9, 8'h00, 8'h02, 1, 1, 0, "sw_tick2");
    act_a(0, 0, 1, 8'h00, 8'h00, 1, 0, 0, "sw_start");
    wait_to(k + 10);
    rst = 1'b1;
    push(0, cyc, 8'h00, 8'h00, 0, 0, 0, "arst");
    step();
    rst = 1'b0;
    push(0, cyc + 1, 8'h00, 8'h00, 0, 0, 0, "post_rst");
    step();

    // Stopwatch seconds-to-minutes carry from 00:58.
    a_mode = 1'b1; a_pm = 8'h00; a_ps = 8'h58;
    act_a(0, 1, 0, 8'h00, 8'h58, 0, 0, 0, "carry_ld");
    a_mode = 1'b0;
    k = cyc;
    push(0, k + 5,  8'h00, 8'h59, 1, 1, 0, "carry_59");
    push(0, k + 9,  8'h01, 8'h00, 1, 1, 0, "carry_100");
    push(0, k + 13, 8'h01, 8'h01, 1, 1, 0, "carry_101");
    act_a(0, 0, 1, 8'h00, 8'h58, 1, 0, 0, "carry_run");
    wait_to(k + 14);
    act_a(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, "clear1");

    // Countdown from 01:01 to 00:00, then DONE ignores start_stop and load.
    a_mode = 1'b1; a_pm = 8'h01; a_ps = 8'h01;
    act_a(0, 1, 0, 8'h01, 8'h01, 0, 0, 0, "cd_load");
    k = cyc;
    for (int n = 1; n <= 61; n++) begin
      t = 61 - n;
      push(0, k + 1 + 4 * n, bcd(t / 60), bcd(t % 60), (t != 0), 1, (t == 0), "cd_tick");
    end
    act_a(0, 0, 1, 8'h01, 8'h01, 1, 0, 0, "cd_run");
    d = k + 1 + 4 * 61;
    wait_to(d + 1);
    act_a(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, "done_ss");
    a_pm = 8'h05; a_ps = 8'h00;
    act_a(0, 1, 0, 8'h00, 8'h00, 0, 0, 1, "done_ld");
    act_a(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, "clear2");

    // Preset validation.
    a_pm = 8'h12; a_ps = 8'h34;
    act_a(0, 1, 0, 8'h12, 8'h34, 0, 0, 0, "ld_ok");
    a_pm = 8'h00; a_ps = 8'h60;
    act_a(0, 1, 0, 8'h12, 8'h34, 0, 0, 0, "ld_sec60");
    a_pm = 8'h0A; a_ps = 8'h00;
    act_a(0, 1, 0, 8'h12, 8'h34, 0, 0, 0, "ld_minA");
    a_mode = 1'b0; a_pm = 8'h05; a_ps = 8'h05;
    act_a(0, 1, 0, 8'h12, 8'h34, 0, 0, 0, "ld_mode0");
    act_a(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, "clear3");
    a_mode = 1'b1;
    act_a(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, "cd_zero");
    act_a(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, "clear4");

    // clear+load+start_stop on a wrap cycle: clear wins, tick suppressed.
    a_pm = 8'h03; a_ps = 8'h00;
    act_a(0, 1, 0, 8'h03, 8'h00, 0, 0, 0, "prio_ld");
    k = cyc;
    act_a(0, 0, 1, 8'h03, 8'h00, 1, 0, 0, "prio_run");
    wait_to(k + 4);
    a_pm = 8'h07;
    act_a(1, 1, 1, 8'h00, 8'h00, 0, 0, 0, "prio_all");

    // Stopwatch saturation at 99:59.
    a_pm = 8'h99; a_ps = 8'h57;
    act_a(0, 1, 0, 8'h99, 8'h57, 0, 0, 0, "sat_ld");
    a_mode = 1'b0;
    k = cyc;
    push(0, k + 5, 8'h99, 8'h58, 1, 1, 0, "sat_58");
    push(0, k + 9, 8'h99, 8'h59, 0, 1, 1, "sat_59");
    act_a(0, 0, 1, 8'h99, 8'h57, 1, 0, 0, "sat_run");
    wait_to(k + 20);
    push(0, cyc, 8'h99, 8'h59, 0, 0, 1, "sat_hold");
    step();

    // Pause/resume on the DIV=8 core.
    b_mode = 1'b0;
    k = cyc;
    act_b(0, 0, 1, 8'h00, 8'h00, 1, 0, 0, "b_start");
    wait_to(k + 3);
    act_b(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, "b_pause");
    r = k + 23;
    wait_to(r);
    push(1, r, 8'h00, 8'h00, 0, 0, 0, "b_held");
    push(1, r + 6, 8'h00, 8'h01, 1, 1, 0, "b_resume");
    act_b(0, 0, 1, 8'h00, 8'h00, 1, 0, 0, "b_run");
    wait_to(r + 13);
    act_b(0, 0, 1, 8'h00, 8'h02, 0, 1, 0, "b_wrappause");
    wait_to(r + 16);
    push(1, r + 25, 8'h00, 8'h03, 1, 1, 0, "b_tick3");
    act_b(0, 0, 1, 8'h00, 8'h02, 1, 0, 0, "b_res2");
    wait_to(r + 26);
    act_b(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, "b_clear");

    step();
    fin = 1'b1;
    repeat (5) step();
    $display("FAIL monitor: summary not reached after finish request");
    $fatal(1, "monitor stalled");
  end

endmodule
